multu_ctrl: RTL and testbench

Multi-cycle sequencer for the MIPS-Lite `MULTU` instruction. It performs a 32-step unsigned shift-add multiply by driving the shared 32-bit EX-stage ALU with ADD operations, and it commits the 64-bit product to architectural HI/LO registers. It sits beside the ALU in the EX stage, takes ownership of the ALU operand mux while running, and stalls the pipeline until the product is ready.

---
 rtl/multu_ctrl.sv | 141 ++++++++++++++
 tb/tb_multu_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/multu_ctrl.sv
// multu_ctrl
// Sequencer for the MIPS-Lite MULTU instruction. Runs a 32-step unsigned
// shift-add multiply on the shared EX-stage ALU using only ADD operations,
// then commits the 64-bit product to the architectural HI/LO registers.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      MULTU issued in EX, sampled only in IDLE
//   flush      synchronous abort; wins over accept and final commit
//   opA, opB   multiplicand / multiplier, captured on accept
//   aluResult  shared ALU result (combinational from aluA/aluB)
//   aluSel     1 while this block owns the ALU operand mux
//   aluA/aluB  ALU operands while owned, zero otherwise
//   aluSignal  ALU op code while owned (3'b010 = ADD), zero otherwise
//   busy       high in RUN
//   stall      pipeline stall request
//   done       one-cycle pulse in DONE; HI/LO are valid
//   hi, lo     architectural HI/LO
//   fsm_state  current FSM state (IDLE=0, RUN=1, DONE=2) for observation
//
// Handshake: there is no backpressure. start is accepted on the edge where
// the FSM is IDLE, start=1 and flush=0; stall is raised combinationally in
// that same cycle and held through RUN, and done marks the single cycle in
// which the new HI/LO are first visible.
module multu_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [WIDTH-1:0] aluResult,
  output logic             aluSel,
  output logic [WIDTH-1:0] aluA,
  output logic [WIDTH-1:0] aluB,
  output logic [2:0]       aluSignal,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       fsm_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0]       ALU_ADD  = 3'b010;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mplr;
  logic [WIDTH-1:0] mcand;
  logic [CNT_W-1:0] cnt;

  logic             carry;
  logic [WIDTH-1:0] next_acc;
  logic [WIDTH-1:0] next_mplr;
  logic             in_run;
  logic             accept;

  assign in_run = (state == S_RUN);
  assign accept = (state == S_IDLE) && start && !flush;

  // ALU operand drive; everything is zero when the ALU is not owned so the
  // EX mux sees a quiet bus.
  always_comb begin
    aluSel    = 1'b0;
    aluA      = '0;
    aluB      = '0;
    aluSignal = 3'b000;
    if (in_run) begin
      aluSel    = 1'b1;
      aluA      = acc;
      aluB      = mplr[0] ? mcand : '0;
      aluSignal = ALU_ADD;
    end
  end

  // The ALU has no carry-out: an unsigned add wrapped exactly when the sum
  // is smaller than one of its addends.
  always_comb begin
    carry     = (aluResult < acc);
    next_acc  = {carry, aluResult[WIDTH-1:1]};
    next_mplr = {aluResult[0], mplr[WIDTH-1:1]};
  end

  assign busy      = in_run;
  assign stall     = in_run | accept;
  assign done      = (state == S_DONE);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      acc   <= '0;
      mplr  <= '0;
      mcand <= '0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            acc   <= '0;
            mplr  <= opB;
            mcand <= opA;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            acc  <= next_acc;
            mplr <= next_mplr;
            cnt  <= cnt + 1'b1;
            // Final step: commit the values being formed this cycle, the
            // working registers are not read again.
            if (cnt == LAST_CNT) begin
              hi    <= next_acc;
              lo    <= next_mplr;
              state <= S_DONE;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multu_ctrl.sv
// tb_multu_ctrl
// Table-driven bench for multu_ctrl with a behavioural ADD-only ALU, plus
// hand-written sequences for flush, ignored start pulses and mid-run reset.
module tb_multu_ctrl;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic          start;
  logic          flush;
  logic [W-1:0]  opA;
  logic [W-1:0]  opB;
  logic [W-1:0]  aluResult;
  logic          aluSel;
  logic [W-1:0]  aluA;
  logic [W-1:0]  aluB;
  logic [2:0]    aluSignal;
  logic          busy;
  logic          stall;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic [1:0]    fsm_state;

  int checks = 0;
  int errors = 0;

  logic [2*W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    int           pulse_step;
    bit           pulse_done;
  } vec_t;

  vec_t vecs[6];

  multu_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .flush     (flush),
    .opA       (opA),
    .opB       (opB),
    .aluResult (aluResult),
    .aluSel    (aluSel),
    .aluA      (aluA),
    .aluB      (aluB),
    .aluSignal (aluSignal),
    .busy      (busy),
    .stall     (stall),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .fsm_state (fsm_state)
  );

  // Shared EX-stage ALU: only ADD is needed here.
  assign aluResult = (aluSignal == 3'b010) ? aluA + aluB : '0;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered just after a rising edge with the DUT in IDLE. Runs one full
  // multiply, optionally pulsing start at a given RUN step and/or in DONE.
  task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                         input int pulse_step, input bit pulse_done);
    int run_bad;
    logic [2*W-1:0] exp;
    exp_q.push_back({exp_hi, exp_lo});
    opA = a; opB = b; start = 1'b1; flush = 1'b0;
    @(negedge clk);
    check("stall_on_accept", stall, 1'b1);
    @(posedge clk); #1;
    run_bad = 0;
    for (int i = 0; i < W; i++) begin
      if (i == pulse_step) begin
        start = 1'b1; opA = ~a; opB = ~b;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (!(busy && stall && aluSel && !done && aluSignal == 3'b010 && fsm_state == 2'd1))
        run_bad++;
      @(posedge clk); #1;
    end
    start = pulse_done;
    if (pulse_done) begin
      opA = 32'h55; opB = 32'h77;
    end
    @(negedge clk);
    exp = exp_q.pop_front();
    check("run_cycles_bad", run_bad, 0);
    check("done_pulse", done, 1'b1);
    check("stall_in_done", stall, 1'b0);
    check("alusel_in_done", aluSel, 1'b0);
    check("hi_lo", {hi, lo}, exp);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("idle_after_done", fsm_state, 2'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int seen_done;

    vecs[0] = '{32'd3,        32'd5,        32'h0000_0000, 32'h0000_000F, -1, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, -1, 1'b0};
    vecs[2] = '{32'h8000_0000, 32'd2,        32'h0000_0001, 32'h0000_0000, -1, 1'b0};
    vecs[3] = '{32'd0,        32'h1234_5678, 32'h0000_0000, 32'h0000_0000, -1, 1'b0};
    vecs[4] = '{32'd4,        32'd5,        32'h0000_0000, 32'd20,          5, 1'b1};
    vecs[5] = '{32'd7,        32'd6,        32'h0000_0000, 32'd42,         -1, 1'b0};

    rst = 1'b0; start = 1'b0; flush = 1'b0; opA = '0; opB = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", fsm_state, 2'd0);
    check("rst_hi_lo", {hi, lo}, 64'd0);
    check("rst_flags", {done, busy, stall, aluSel}, 4'b0000);
    check("rst_alu_bus", {aluA, aluB, aluSignal}, 67'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // start together with flush in IDLE: no accept
    opA = 32'd9; opB = 32'd9; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("start_flush_stall", stall, 1'b0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("start_flush_idle", fsm_state, 2'd0);
    @(posedge clk); #1;

    foreach (vecs[k])
      do_mult(vecs[k].a, vecs[k].b, vecs[k].exp_hi, vecs[k].exp_lo,
              vecs[k].pulse_step, vecs[k].pulse_done);

    // Flush 9x9 at RUN step 10: back to IDLE, no done, HI/LO keep 0/42
    opA = 32'd9; opB = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_idle", fsm_state, 2'd0);
    check("flush_busy", busy, 1'b0);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("flush_no_done", seen_done, 0);
    check("flush_hi_lo_kept", {hi, lo}, {32'd0, 32'd42});
    @(posedge clk); #1;

    // Reset asserted between edges mid-RUN
    opA = 32'd9; opB = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b0;
    #1;
    check("midrun_rst_state", fsm_state, 2'd0);
    check("midrun_rst_flags", {done, busy, stall, aluSel}, 4'b0000);
    check("midrun_rst_hi_lo", {hi, lo}, 64'd0);
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    do_mult(32'd2, 32'd3, 32'd0, 32'd6, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
